// File: rtl/exe_mem_ctrl.sv
// exe_mem_ctrl: execute-to-bus memory access controller with in-order tracking,
// store lane replication, load extraction/extension and flush cancellation.
module exe_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                flush,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [31:0]         data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_ale
);
    localparam int SW = DATA_W / 8;
    localparam int OW = $clog2(SW);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = DEPTH;

    typedef struct packed {
        logic              done;
        logic              err;
        logic              wr;
        logic              sext;
        logic [1:0]        size;
        logic [OW-1:0]     off;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              ent_q [DEPTH];
    ent_t              ent_d [DEPTH];
    ent_t              head_e;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, tgt, idx;
    logic [CW-1:0]     cnt_q, cnt_d, cancel_q, cancel_d, nout;
    logic              has_tgt, aligned, slot_free, accept, pop, sbit;
    logic [2:0]        amask;
    logic [15:0]       strb_w;
    logic [DATA_W-1:0] shifted, msk;

    always_comb begin
        amask      = (3'd1 << req_size) - 3'd1;
        aligned    = (req_addr[2:0] & amask) == 3'd0;
        slot_free  = ({1'b0, cnt_q} + {1'b0, cancel_q}) < DEPTH_V;
        data_req   = req_valid & aligned & ~flush & slot_free;
        req_ready  = slot_free & ~flush & (~aligned | data_addr_ok);
        accept     = req_valid & req_ready;
        data_wr    = req_wr;
        data_size  = req_size;
        data_addr  = req_addr;
        strb_w     = ((16'd1 << (5'd1 << req_size)) - 16'd1) << req_addr[OW-1:0];
        data_wstrb = req_wr ? strb_w[SW-1:0] : '0;
        data_wdata = req_size == 2'd0 ? {SW{req_wdata[7:0]}} :
                     req_size == 2'd1 ? {(SW/2){req_wdata[15:0]}} :
                     req_size == 2'd2 ? {(SW/4){req_wdata[31:0]}} : req_wdata;
        // load extraction: shift the addressed bytes down, then mask and extend
        head_e     = ent_q[head_q];
        resp_valid = (cnt_q != '0) & head_e.done;
        resp_ale   = resp_valid & head_e.err;
        shifted    = head_e.data >> {head_e.off, 3'b000};
        msk        = head_e.size == 2'd0 ? DATA_W'(8'hFF) :
                     head_e.size == 2'd1 ? DATA_W'(16'hFFFF) :
                     head_e.size == 2'd2 ? DATA_W'(32'hFFFF_FFFF) : '1;
        sbit       = head_e.size == 2'd0 ? shifted[7] : head_e.size == 2'd1 ? shifted[15] : shifted[31];
        resp_data  = (resp_valid & ~head_e.err & ~head_e.wr) ?
                     ((shifted & msk) | ((head_e.sext & sbit) ? ~msk : '0)) : '0;
        pop        = resp_valid & resp_ready;
        // oldest bus entry still awaiting data, plus the issued-but-unreturned count
        nout    = '0;
        has_tgt = 1'b0;
        tgt     = head_q;
        idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < cnt_q && !ent_q[idx].done) begin
                nout = nout + CW'(1);
                if (!has_tgt) begin
                    has_tgt = 1'b1;
                    tgt     = idx;
                end
            end
        end
        ent_d    = ent_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        cancel_d = cancel_q;
        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            cnt_d    = '0;
            cancel_d = cancel_q + nout - CW'(data_data_ok & (cancel_q != '0 | nout != '0));
        end else begin
            if (data_data_ok) begin
                if (cancel_q != '0) begin
                    cancel_d = cancel_q - CW'(1);
                end else if (has_tgt) begin
                    ent_d[tgt].done = 1'b1;
                    ent_d[tgt].data = data_rdata;
                end
            end
            if (pop) head_d = head_q + PW'(1);
            if (accept) begin
                ent_d[tail_q].done = ~aligned;
                ent_d[tail_q].err  = ~aligned;
                ent_d[tail_q].wr   = req_wr;
                ent_d[tail_q].sext = req_sext;
                ent_d[tail_q].size = req_size;
                ent_d[tail_q].off  = req_addr[OW-1:0];
                ent_d[tail_q].data = '0;
                tail_d             = tail_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            cancel_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
            ent_q    <= ent_d;
        end
    end
endmodule

// File: doc/exe_mem_ctrl.md
EXE_MEM_CTRL -- requirements
Module: exe_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data bus width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 2, max in-flight accesses; power of two, >=2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  execute stage presents a memory access.
REQ-006 req_ready  output  1  access accepted this cycle.
REQ-007 req_wr  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 byte, 1 half, 2 word, 3 double (legal only when DATA_W=64).
REQ-009 req_sext  input  1  load result is sign-extended; 0 = zero-extended.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  DATA_W  store data, right-aligned.
REQ-012 flush  input  1  exception or ertn flush; cancels all in-flight accesses.
REQ-013 data_req  output  1  bus request.
REQ-014 data_wr  output  1  bus write.
REQ-015 data_size  output  2  equals req_size.
REQ-016 data_addr  output  32  equals req_addr.
REQ-017 data_wstrb  output  DATA_W/8  byte enables.
REQ-018 data_wdata  output  DATA_W  lane-replicated store data.
REQ-019 data_addr_ok  input  1  bus accepted the request.
REQ-020 data_data_ok  input  1  bus returns a response; in order, never stalled.
REQ-021 data_rdata  input  DATA_W  read data, valid with data_data_ok.
REQ-022 resp_valid  output  1  head access complete.
REQ-023 resp_ready  input  1  memory stage consumes the response.
REQ-024 resp_data  output  DATA_W  aligned, extended load data; 0 for stores and errors.
REQ-025 resp_ale  output  1  address-misalignment error (ADEM) for this access.

Function
REQ-026 Misaligned = req_addr mod 2^req_size != 0; misaligned accesses never raise data_req.
REQ-027 data_req = req_valid & aligned & !flush & slot_free; req_ready = slot_free & !flush & (!aligned | data_addr_ok); both combinational.
REQ-028 slot_free = (occupancy + cancel_cnt) < DEPTH, evaluated from registered state only; no same-cycle pop bypass.
REQ-029 data_wstrb = (2^(2^size) - 1) << addr low bits (log2(DATA_W/8) bits); 0 when data_wr=0.
REQ-030 data_wdata: size 0 replicates byte, 1 half, 2 word across DATA_W; size 3 passes through.
REQ-031 Each accepted access pushes an in-order tracking entry {err, wr, size, sext, offset}; err entries are marked complete immediately.
REQ-032 data_data_ok writes data_rdata into the oldest bus entry not yet completed and marks it complete; visible on resp_valid next cycle (1-cycle latency).
REQ-033 resp_valid = head entry complete; entry pops when resp_valid & resp_ready; a completed head holds indefinitely while resp_ready=0.
REQ-034 resp_data for loads = bytes at offset, sign- or zero-extended to DATA_W.
REQ-035 flush: all entries cleared next edge; cancel_cnt loads (issued-but-unreturned count); pending and subsequent data_data_ok decrement cancel_cnt and are dropped until zero.
REQ-036 flush with concurrent data_data_ok: that response is dropped and not counted in cancel_cnt.
REQ-037 data_data_ok with no issued access outstanding is ignored; no state change.

Reset
REQ-038 rst clears occupancy, pointers and cancel_cnt; resp_valid=0, resp_ale=0, resp_data=0, data_req=0; req_ready=1 once rst deasserts with req_valid & misaligned, else per REQ-027.

Verification
REQ-039 Load byte addr 0x1003, sext=1, rdata 0x80xxxxxx, data_addr_ok same cycle, data_data_ok +2 cycles -> resp_data 0xFFFFFF80 one cycle later.
REQ-040 Store half addr 0x1002, wdata 0x1234 -> data_wstrb 4'b1100, data_wdata 0x12341234, resp_data 0.
REQ-041 Load word addr 0x1001 -> no data_req, req_ready=1, resp_valid next cycle with resp_ale=1.
REQ-042 DEPTH=2, data_data_ok withheld -> third request sees req_ready=0 until first response popped.
REQ-043 Two loads issued, flush, then two data_data_ok -> no resp_valid; a post-flush load returns its own data correctly.
REQ-044 DATA_W=64, size 3 addr 0x8, resp_ready held 0 for 5 cycles -> resp_valid, resp_data stable throughout.
